// File: rtl/i2s_tx_if.sv
// FIFO read-port bundle between the I2S sample FIFO and the transmitter.
// The FIFO presents its head word show-ahead; the transmitter pops with fifo_ren.
interface i2s_tx_if #(
  parameter int unsigned DW = 16
) ();
  logic          fifo_empty;
  logic [2*DW-1:0] fifo_rdt;
  logic          fifo_ren;

  // Transmitter side
  modport master (
    input  fifo_empty,
    input  fifo_rdt,
    output fifo_ren
  );

  // FIFO side
  modport slave (
    output fifo_empty,
    output fifo_rdt,
    input  fifo_ren
  );
endinterface

// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter. Fetches one stereo frame per audio frame from a
// show-ahead FIFO and serialises it on SD with a one-BCLK delay after LRCK changes.
// An empty FIFO at fetch time yields a silent frame and an underrun event.
module i2s_tx #(
  parameter int unsigned DW       = 16,
  parameter int unsigned SLOT     = 16,
  parameter int unsigned BCLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  i2s_tx_if.master    fifo,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sd,
  output logic        underrun,
  output logic [7:0]  underrun_cnt
);

  localparam int unsigned FW = 2 * DW;
  localparam int unsigned BW = $clog2(2 * SLOT);
  localparam int unsigned CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [CW-1:0] DLast = CW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BLast = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] BOne  = BW'(1);
  localparam logic [BW-1:0] SlotB = BW'(SLOT);
  localparam logic [BW-1:0] DwB   = BW'(DW);

  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [BW-1:0] b_q, b_d;
  logic          bclk_q, bclk_d;
  logic          lrck_q, lrck_d;
  logic          sd_q, sd_d;
  logic          ren_q, ren_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    ucnt_q, ucnt_d;
  logic [FW-1:0] pend_q, pend_d;
  logic [FW-1:0] act_q, act_d;

  logic          fall;
  logic [BW-1:0] b_next;
  logic          right;
  logic [BW-1:0] k;
  logic [FW-1:0] frame;
  logic [DW-1:0] sample;
  logic [DW-1:0] shifted;

  // Bit-slot decode for the slot being entered on a falling BCLK edge
  always_comb begin
    fall    = en && (dcnt_q == DLast) && bclk_q;
    b_next  = (b_q == BLast) ? '0 : b_q + 1'b1;
    // The bit emitted when entering b belongs to position b-1 (I2S one-bit delay)
    right   = (b_q >= SlotB);
    k       = right ? (b_q - SlotB) : b_q;
    // Entering b=1 starts the newly fetched frame, so its MSB comes from pending
    frame   = (b_next == BOne) ? pend_q : act_q;
    sample  = right ? frame[DW-1:0] : frame[FW-1:DW];
    shifted = sample << k;
  end

  // Next-state: divider, bit position, serial outputs and frame fetch
  always_comb begin
    dcnt_d     = dcnt_q;
    b_d        = b_q;
    bclk_d     = bclk_q;
    lrck_d     = lrck_q;
    sd_d       = sd_q;
    ren_d      = 1'b0;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;
    pend_d     = pend_q;
    act_d      = act_q;
    if (!en) begin
      // Idle/abort: anything already popped is dropped
      dcnt_d = '0;
      b_d    = BLast;
      bclk_d = 1'b1;
      lrck_d = 1'b0;
      sd_d   = 1'b0;
      pend_d = '0;
      act_d  = '0;
    end else begin
      if (dcnt_q == DLast) begin
        dcnt_d = '0;
        bclk_d = ~bclk_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
      if (fall) begin
        b_d    = b_next;
        lrck_d = (b_next >= SlotB);
        sd_d   = (k < DwB) ? shifted[DW-1] : 1'b0;
        if (b_next == BOne) begin
          act_d = pend_q;
        end
        if (b_next == '0) begin
          if (!fifo.fifo_empty) begin
            ren_d  = 1'b1;
            pend_d = fifo.fifo_rdt;
          end else begin
            pend_d     = '0;
            underrun_d = 1'b1;
            if (ucnt_q != 8'hFF) begin
              ucnt_d = ucnt_q + 8'd1;
            end
          end
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q     <= '0;
      b_q        <= BLast;
      bclk_q     <= 1'b1;
      lrck_q     <= 1'b0;
      sd_q       <= 1'b0;
      ren_q      <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
      pend_q     <= '0;
      act_q      <= '0;
    end else begin
      dcnt_q     <= dcnt_d;
      b_q        <= b_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      sd_q       <= sd_d;
      ren_q      <= ren_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
    end
  end

  assign fifo.fifo_ren = ren_q;
  assign i2s_bclk      = bclk_q;
  assign i2s_lrck      = lrck_q;
  assign i2s_sd        = sd_q;
  assign underrun      = underrun_q;
  assign underrun_cnt  = ucnt_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: framing, data order, underrun, abort, reset, saturation,
// plus a SLOT=24 instance for zero-padded slots.
module tb_i2s_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en24 = 1'b0;

  always #5 clk = ~clk;

  i2s_tx_if #(.DW(16)) bus ();
  i2s_tx_if #(.DW(16)) bus24 ();

  logic       bclk, lrck, sd, und;
  logic [7:0] ucnt;
  logic       bclk24, lrck24, sd24, und24;
  logic [7:0] ucnt24;

  i2s_tx #(.DW(16), .SLOT(16), .BCLK_DIV(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .fifo         (bus),
    .i2s_bclk     (bclk),
    .i2s_lrck     (lrck),
    .i2s_sd       (sd),
    .underrun     (und),
    .underrun_cnt (ucnt)
  );

  i2s_tx #(.DW(16), .SLOT(24), .BCLK_DIV(2)) dut24 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en24),
    .fifo         (bus24),
    .i2s_bclk     (bclk24),
    .i2s_lrck     (lrck24),
    .i2s_sd       (sd24),
    .underrun     (und24),
    .underrun_cnt (ucnt24)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;
  int n0;

  logic [31:0] fq[$];
  logic        sdq[$];
  logic        lrq[$];
  logic        sdq24[$];
  logic        lrq24[$];
  int          renq[$];
  int          renq24[$];
  int          urq[$];
  logic        bclk_p = 1'b1;
  logic        bclk24_p = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_rdt   = (fq.size() == 0) ? 32'h0 : fq[0];
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    drive_fifo();
  endtask

  // One clock: sample #1 after the edge, log falling BCLK bits, serve pops
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bclk_p && !bclk) begin
      sdq.push_back(sd);
      lrq.push_back(lrck);
    end
    bclk_p = bclk;
    if (bclk24_p && !bclk24) begin
      sdq24.push_back(sd24);
      lrq24.push_back(lrck24);
    end
    bclk24_p = bclk24;
    if (bus.fifo_ren) begin
      renq.push_back(cyc);
      if (fq.size() > 0) void'(fq.pop_front());
      drive_fifo();
    end
    if (bus24.fifo_ren) renq24.push_back(cyc);
    if (und) urq.push_back(cyc);
  endtask

  task automatic wait_falls(input bit sel24, input int n, input int budget, input string tag);
    int t = 0;
    while (((sel24 ? sdq24.size() : sdq.size()) < n) && (t < budget)) begin
      tick();
      t++;
    end
    check(tag, ((sel24 ? sdq24.size() : sdq.size()) >= n), 1);
  endtask

  // Pack n logged bits (first = MSB) starting at fall index start
  function automatic logic [63:0] pack(input bit sel24, input bit lr, input int start,
                                       input int n);
    logic [63:0] w = '0;
    for (int i = 0; i < n; i++) begin
      logic bt;
      if (sel24) bt = lr ? lrq24[start+i] : sdq24[start+i];
      else       bt = lr ? lrq[start+i]   : sdq[start+i];
      w = {w[62:0], bt};
    end
    return w;
  endfunction

  task automatic clear_logs();
    sdq.delete();
    lrq.delete();
    renq.delete();
  endtask

  initial begin
    bus.fifo_empty   = 1'b1;
    bus.fifo_rdt     = 32'h0;
    bus24.fifo_empty = 1'b0;
    bus24.fifo_rdt   = 32'hFFFF_FFFF;

    // Reset values
    repeat (3) tick();
    check("rst_bclk", bclk, 1);
    check("rst_lrck", lrck, 0);
    check("rst_sd", sd, 0);
    check("rst_ren", bus.fifo_ren, 0);
    check("rst_underrun", und, 0);
    check("rst_cnt", ucnt, 0);
    check("rst_bclk24", bclk24, 1);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_ren", bus.fifo_ren, 0);
    check("idle_bclk", bclk, 1);

    // Four queued frames, then an empty fetch
    push(32'hA5A5_3C3C);
    push(32'h1234_5678);
    push(32'h8000_0001);
    push(32'hDEAD_BEEF);
    en = 1'b1;
    t0 = cyc;
    wait_falls(0, 161, 1000, "t1_timeout");
    check("t1_ren_count", renq.size(), 4);
    check("t1_ren_latency", renq[0] - t0, 2);
    check("t1_ren_period01", renq[1] - renq[0], 128);
    check("t1_ren_period23", renq[3] - renq[2], 128);
    check("t1_lrck_frame0", pack(0, 1, 0, 32), 64'h0000_FFFF);
    check("t1_lrck_frame1", pack(0, 1, 32, 32), 64'h0000_FFFF);
    check("t1_b0_sd", sdq[0], 0);
    check("t1_word0", pack(0, 0, 1, 32), 64'hA5A5_3C3C);
    check("t1_word1", pack(0, 0, 33, 32), 64'h1234_5678);
    check("t1_word2", pack(0, 0, 65, 32), 64'h8000_0001);
    check("t1_word3", pack(0, 0, 97, 32), 64'hDEAD_BEEF);
    check("t1_prev_lsb_at_b0", sdq[128], 1);
    check("t1_silent_frame", pack(0, 0, 129, 32), 64'h0);
    check("t1_ur_count", urq.size(), 2);
    check("t1_ur_cycle", urq[0] - renq[0], 512);
    check("t1_ucnt", ucnt, 2);

    en = 1'b0;
    tick();
    check("dis_bclk", bclk, 1);
    check("dis_lrck", lrck, 0);
    check("dis_sd", sd, 0);
    check("dis_ucnt_held", ucnt, 2);

    // Abort at b=10, restart five clocks later
    clear_logs();
    push(32'h0F0F_0F0F);
    push(32'hC3C3_C3C3);
    en = 1'b1;
    wait_falls(0, 11, 200, "ab_timeout");
    check("ab_b10_lrck", lrck, 0);
    en = 1'b0;
    tick();
    check("ab_idle_bclk", bclk, 1);
    check("ab_idle_lrck", lrck, 0);
    check("ab_idle_sd", sd, 0);
    check("ab_fifo_left", fq.size(), 1);
    repeat (4) tick();
    check("ab_no_ren_idle", renq.size(), 1);
    clear_logs();
    en = 1'b1;
    t0 = cyc;
    wait_falls(0, 33, 300, "ab2_timeout");
    check("ab2_ren_latency", renq[0] - t0, 2);
    check("ab2_b0_sd", sdq[0], 0);
    check("ab2_word", pack(0, 0, 1, 32), 64'hC3C3_C3C3);
    check("ab2_ucnt", ucnt, 3);

    // Asynchronous reset inside the right slot
    repeat (70) tick();
    check("pre_rst_lrck", lrck, 1);
    check("pre_rst_ucnt", ucnt, 3);
    rst_n = 1'b0;
    #1;
    check("arst_bclk", bclk, 1);
    check("arst_lrck", lrck, 0);
    check("arst_sd", sd, 0);
    check("arst_ucnt", ucnt, 0);
    check("arst_underrun", und, 0);
    #2;
    rst_n = 1'b1;
    clear_logs();
    push(32'h5A5A_5A5A);
    t0 = cyc;
    wait_falls(0, 33, 300, "rs_timeout");
    check("rs_ren_latency", renq[0] - t0, 2);
    check("rs_word", pack(0, 0, 1, 32), 64'h5A5A_5A5A);
    check("rs_ucnt", ucnt, 1);

    // 300 empty frames: counter saturates, pulses continue
    n0 = urq.size();
    repeat (300 * 128) tick();
    check("sat_pulses", urq.size() - n0, 300);
    check("sat_ucnt", ucnt, 255);
    check("sat_pulse_period", urq[urq.size()-1] - urq[urq.size()-2], 128);
    check("sat_no_ren", renq.size(), 1);

    // SLOT=24: 16 data bits then 8 zero pad bits per slot
    en = 1'b0;
    en24 = 1'b1;
    t0 = cyc;
    wait_falls(1, 49, 600, "s24_timeout");
    check("s24_ren_latency", renq24[0] - t0, 2);
    check("s24_ren_period", renq24[1] - renq24[0], 192);
    check("s24_sd", pack(1, 0, 1, 48), {16'h0, 16'hFFFF, 8'h00, 16'hFFFF, 8'h00});
    check("s24_lrck", pack(1, 1, 0, 48), {16'h0, 24'h000000, 24'hFFFFFF});
    check("s24_ucnt", ucnt24, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
